// File: rtl/cv32e40p_rf_ecc_pkg.sv
// Shared definitions for the (38,32) Hamming-protected register file:
// codeword geometry, parity positions, syndrome type and scrubber states.
package cv32e40p_rf_ecc_pkg;

  localparam int CW_WIDTH   = 38;
  localparam int DATA_WIDTH = 32;
  localparam int SYN_WIDTH  = 6;

  localparam int PARITY_POS [SYN_WIDTH] = '{1, 2, 4, 8, 16, 32};

  typedef logic [SYN_WIDTH-1:0] syndrome_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_WRITE,
    S_NEXT,
    S_WAIT
  } scrub_state_e;

  // Positions are 1-based, matching the Hamming numbering.
  function automatic logic is_parity_pos(input int pos);
    for (int i = 0; i < SYN_WIDTH; i++) begin
      if (PARITY_POS[i] == pos) return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/cv32e40p_register_file_decoder.sv
// Combinational (38,32) Hamming decoder: syndrome, single-bit repair and data
// extraction. Shared between the scrubber and the core read ports.
module cv32e40p_register_file_decoder
  import cv32e40p_rf_ecc_pkg::*;
(
  input  logic [CW_WIDTH-1:0]   codeword,
  output syndrome_t             syndrome,
  output logic [CW_WIDTH-1:0]   corr_cw,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  correctable,
  output logic                  uncorrectable
);

  always_comb begin
    syndrome = '0;
    for (int p = 1; p <= CW_WIDTH; p++) begin
      for (int k = 0; k < SYN_WIDTH; k++) begin
        if (p[k]) syndrome[k] = syndrome[k] ^ codeword[p-1];
      end
    end
  end

  assign correctable   = (syndrome != '0) && (syndrome <= syndrome_t'(CW_WIDTH));
  assign uncorrectable = (syndrome > syndrome_t'(CW_WIDTH));

  // Syndrome s names position s, which is codeword bit s-1 (parity bits included).
  always_comb begin
    corr_cw = codeword;
    if (correctable) corr_cw[syndrome - 6'd1] = ~codeword[syndrome - 6'd1];
  end

  always_comb begin
    int j;
    j    = 0;
    data = '0;
    for (int p = 1; p <= CW_WIDTH; p++) begin
      if (!is_parity_pos(p)) begin
        data[j] = corr_cw[p-1];
        j       = j + 1;
      end
    end
  end

endmodule

// File: rtl/cv32e40p_register_file_scrubber.sv
// Background scrubber: sweeps the register file through a spare port, repairs
// single-bit errors by write-back and flags uncorrectable codewords.
//
// state  | meaning
// IDLE   | scrubbing disabled, address parked at 0
// READ   | request codeword at addr (held off while the core owns the port)
// CHECK  | decode returned codeword, classify syndrome
// WRITE  | write corrected codeword back (held off while port busy)
// NEXT   | advance address or close the sweep
// WAIT   | idle interval between sweeps
module cv32e40p_register_file_scrubber
  import cv32e40p_rf_ecc_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int SCRUB_INTERVAL = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scrub_en_i,
  input  logic                  rf_busy_i,
  output logic                  rreq_o,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  input  logic [CW_WIDTH-1:0]   rdata_i,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [CW_WIDTH-1:0]   wdata_o,
  input  logic                  core_we_i,
  input  logic [ADDR_WIDTH-1:0] core_waddr_i,
  output logic [CNT_WIDTH-1:0]  corr_cnt_o,
  output logic                  err_uncorr_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic                  sweep_done_o
);

  localparam int WAIT_W = (SCRUB_INTERVAL > 0) ? $clog2(SCRUB_INTERVAL + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  scrub_state_e          state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [CW_WIDTH-1:0]   corr_cw_q;

  syndrome_t             unused_dec_syn;
  logic [CW_WIDTH-1:0]   dec_cw;
  logic [DATA_WIDTH-1:0] unused_dec_data;
  logic                  dec_corr;
  logic                  dec_uncorr;
  logic                  core_hit;

  cv32e40p_register_file_decoder u_decoder (
    .codeword      (rdata_i),
    .syndrome      (unused_dec_syn),
    .corr_cw       (dec_cw),
    .data          (unused_dec_data),
    .correctable   (dec_corr),
    .uncorrectable (dec_uncorr)
  );

  assign core_hit = core_we_i && (core_waddr_i == addr_q);

  // Port strobes are qualified by same-cycle busy/core-write so the scrubber
  // never collides with the core on the shared port or overwrites fresh data.
  assign rreq_o  = (state == S_READ) && !rf_busy_i;
  assign we_o    = (state == S_WRITE) && !rf_busy_i && !core_hit;
  assign raddr_o = addr_q;
  assign waddr_o = addr_q;
  assign wdata_o = corr_cw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      wait_cnt     <= '0;
      corr_cw_q    <= '0;
      corr_cnt_o   <= '0;
      err_uncorr_o <= 1'b0;
      err_addr_o   <= '0;
      sweep_done_o <= 1'b0;
    end else begin
      err_uncorr_o <= 1'b0;
      sweep_done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          addr_q <= '0;
          if (scrub_en_i) state <= S_READ;
        end
        S_READ: begin
          if (!scrub_en_i) begin
            addr_q <= '0;
            state  <= S_IDLE;
          end else if (!rf_busy_i) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          corr_cw_q <= dec_cw;
          if (dec_uncorr) begin
            err_uncorr_o <= 1'b1;
            err_addr_o   <= addr_q;
            state        <= S_NEXT;
          end else if (dec_corr && !core_hit) begin
            state <= S_WRITE;
          end else begin
            state <= S_NEXT;
          end
        end
        S_WRITE: begin
          if (core_hit) begin
            state <= S_NEXT;
          end else if (!rf_busy_i) begin
            if (corr_cnt_o != '1) corr_cnt_o <= corr_cnt_o + 1'b1;
            err_addr_o <= addr_q;
            state      <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (addr_q == LAST_ADDR) begin
            sweep_done_o <= 1'b1;
            addr_q       <= '0;
            wait_cnt     <= WAIT_W'(SCRUB_INTERVAL);
            state        <= scrub_en_i ? S_WAIT : S_IDLE;
          end else if (scrub_en_i) begin
            addr_q <= addr_q + 1'b1;
            state  <= S_READ;
          end else begin
            addr_q <= '0;
            state  <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (!scrub_en_i) begin
            addr_q <= '0;
            state  <= S_IDLE;
          end else if (wait_cnt == '0) begin
            state <= S_READ;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_register_file_scrubber.sv
// Directed bench for the register file scrubber with a behavioural register
// file model and a write-back scoreboard.
module tb_cv32e40p_register_file_scrubber;

  typedef struct packed {
    logic [4:0]  addr;
    logic [37:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scrub_en_i = 1'b0;
  logic        rf_busy_i = 1'b0;
  logic        rreq_o;
  logic [4:0]  raddr_o;
  logic [37:0] rdata_i = '0;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [37:0] wdata_o;
  logic        core_we_i = 1'b0;
  logic [4:0]  core_waddr_i = '0;
  logic [15:0] corr_cnt_o;
  logic        err_uncorr_o;
  logic [4:0]  err_addr_o;
  logic        sweep_done_o;

  cv32e40p_register_file_scrubber #(
    .NUM_REGS       (32),
    .ADDR_WIDTH     (5),
    .SCRUB_INTERVAL (0),
    .CNT_WIDTH      (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .scrub_en_i   (scrub_en_i),
    .rf_busy_i    (rf_busy_i),
    .rreq_o       (rreq_o),
    .raddr_o      (raddr_o),
    .rdata_i      (rdata_i),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .core_we_i    (core_we_i),
    .core_waddr_i (core_waddr_i),
    .corr_cnt_o   (corr_cnt_o),
    .err_uncorr_o (err_uncorr_o),
    .err_addr_o   (err_addr_o),
    .sweep_done_o (sweep_done_o)
  );

  always #5 clk = ~clk;

  logic [37:0] mem [32];
  logic [37:0] core_wdata = '0;
  wr_t         exp_wr [$];
  wr_t         obs_wr [$];
  logic [4:0]  obs_ue [$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          done_cyc = 0;
  int          prev_done = 0;
  int          busy_viol = 0;
  bit          done_seen;
  bit          last_rreq;
  bit          last_we;
  logic [4:0]  last_raddr;
  bit          ok;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  // One clock: sample at the falling edge, update the model, return just after the rising edge.
  task automatic step();
    logic        rd_valid;
    logic [4:0]  rd_addr;
    @(negedge clk);
    cyc++;
    done_seen  = sweep_done_o;
    last_rreq  = rreq_o;
    last_we    = we_o;
    last_raddr = raddr_o;
    if (sweep_done_o) done_cyc = cyc;
    if (rf_busy_i && (rreq_o || we_o)) busy_viol++;
    if (err_uncorr_o) obs_ue.push_back(err_addr_o);
    if (we_o) begin
      obs_wr.push_back('{addr: waddr_o, data: wdata_o});
      mem[waddr_o] = wdata_o;
    end
    if (core_we_i) mem[core_waddr_i] = core_wdata;
    rd_valid = rreq_o;
    rd_addr  = raddr_o;
    @(posedge clk);
    #1;
    rdata_i = rd_valid ? mem[rd_addr] : '0;
  endtask

  task automatic run_to_done(input string name);
    for (int i = 0; i < 400; i++) begin
      step();
      if (done_seen) return;
    end
    check({name, "_timeout"}, 1, 0);
  endtask

  task automatic wait_read(input logic [4:0] a, input string name);
    for (int i = 0; i < 200; i++) begin
      step();
      if (last_rreq && last_raddr == a) return;
    end
    check({name, "_timeout"}, 1, 0);
  endtask

  task automatic pop_wr(input string name);
    wr_t e, o;
    if (exp_wr.size() == 0 || obs_wr.size() == 0) begin
      check({name, "_present"}, obs_wr.size(), exp_wr.size());
      return;
    end
    e = exp_wr.pop_front();
    o = obs_wr.pop_front();
    check({name, "_addr"}, o.addr, e.addr);
    check({name, "_data"}, o.data, e.data);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // Reset state
    repeat (2) step();
    check("rst_rreq", rreq_o, 0);
    check("rst_we", we_o, 0);
    check("rst_cnt", corr_cnt_o, 0);
    check("rst_uerr", err_uncorr_o, 0);
    check("rst_erraddr", err_addr_o, 0);
    check("rst_done", sweep_done_o, 0);
    rst = 1'b0;
    step();

    // Clean sweep: done pulse 97 cycles after enable
    scrub_en_i = 1'b1;
    cyc = -1;
    run_to_done("sweep0");
    check("sweep0_cycle", done_cyc, 97);
    check("sweep0_nowr", obs_wr.size(), 0);
    check("sweep0_cnt", corr_cnt_o, 0);
    prev_done = done_cyc;

    // Data bit flip at 5, parity p8 flip at 9, double error at 3
    mem[5] = 38'h4;
    mem[9] = 38'h80;
    mem[3] = 38'h20_0000_0001;
    exp_wr.push_back('{addr: 5'd5, data: 38'h0});
    exp_wr.push_back('{addr: 5'd9, data: 38'h0});
    run_to_done("sweep1");
    check("sweep1_period", done_cyc - prev_done, 99);
    prev_done = done_cyc;
    pop_wr("wr5");
    pop_wr("wr9");
    check("sweep1_extra_wr", obs_wr.size(), 0);
    check("sweep1_cnt", corr_cnt_o, 2);
    check("sweep1_erraddr", err_addr_o, 9);
    check("uerr_count", obs_ue.size(), 1);
    if (obs_ue.size() > 0) check("uerr_addr", obs_ue.pop_front(), 3);
    check("mem3_untouched", mem[3], 38'h20_0000_0001);

    // Core write to the same entry during CHECK cancels the write-back
    mem[5] = 38'h4;
    wait_read(5'd5, "conflict_read");
    core_we_i    = 1'b1;
    core_waddr_i = 5'd5;
    core_wdata   = 38'h0;
    step();
    core_we_i = 1'b0;
    run_to_done("sweep2");
    check("sweep2_period", done_cyc - prev_done, 97);
    prev_done = done_cyc;
    check("conflict_nowr", obs_wr.size(), 0);
    check("conflict_cnt", corr_cnt_o, 2);
    check("conflict_mem5", mem[5], 0);

    // Stalls: 4 cycles in READ, 2 cycles in WRITE on entry 7
    mem[7] = 38'h4;
    exp_wr.push_back('{addr: 5'd7, data: 38'h0});
    wait_read(5'd6, "stall_pre");
    step();
    step();
    rf_busy_i = 1'b1;
    repeat (4) step();
    rf_busy_i = 1'b0;
    step();
    check("stall_rreq_after", last_rreq, 1);
    check("stall_raddr_after", last_raddr, 7);
    step();
    rf_busy_i = 1'b1;
    repeat (2) step();
    rf_busy_i = 1'b0;
    step();
    check("stall_we_after", last_we, 1);
    run_to_done("sweep3");
    check("sweep3_period", done_cyc - prev_done, 104);
    prev_done = done_cyc;
    check("stall_busy_viol", busy_viol, 0);
    pop_wr("wr7");
    check("stall_cnt", corr_cnt_o, 3);

    // Asynchronous reset during the write-back cycle
    mem[4] = 38'h4;
    wait_read(5'd4, "rstwr_read");
    step();
    #1;
    check("rstwr_we_before", we_o, 1);
    rst = 1'b1;
    #1;
    check("rstwr_we_dropped", we_o, 0);
    check("rstwr_cnt_cleared", corr_cnt_o, 0);
    repeat (2) step();
    rst = 1'b0;
    check("rstwr_nowr", obs_wr.size(), 0);
    exp_wr.push_back('{addr: 5'd4, data: 38'h0});
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      ok = last_rreq;
    end
    check("restart_rreq_seen", ok, 1);
    check("restart_raddr", last_raddr, 0);
    run_to_done("sweep4");
    pop_wr("wr4");
    check("restart_cnt", corr_cnt_o, 1);
    check("restart_erraddr", err_addr_o, 4);

    check("final_exp_empty", exp_wr.size(), 0);
    check("final_obs_empty", obs_wr.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
